// File: rtl/mp_serial_link.sv
// mp_serial_link
// Full-duplex two-wire link between two boards. The transmitter frames the local
// player state continuously. The receiver deserialises and checks the peer's frames
// and reports the peer state plus a link-up flag.
//
// Frame: start(0) | payload LSB-first {reload, pause, score} | even parity | stop(1)
// The transmitter adds IDLE_BITS high bits between frames.
//
// Ports
//   clk              system clock
//   rst              synchronous, active-high reset
//   local_score      local score, sampled on the first cycle of each TX start bit
//   local_pause      local pause request, sampled with local_score
//   local_reload     local reload request, sampled with local_score
//   tx_line          registered serial output, idle high
//   rx_line          serial input from the peer, asynchronous
//   peer_score       last good received score
//   peer_pause       last good received pause
//   peer_reload      last good received reload (level)
//   peer_reload_tick one-cycle pulse when peer_reload rises on a frame update
//   peer_connected   high while good frames keep arriving
//   frame_err_ctr    saturating count of rejected frames
module mp_serial_link #(
  parameter int SCORE_W     = 4,
  parameter int BIT_CYCLES  = 650,
  parameter int IDLE_BITS   = 2,
  parameter int TIMEOUT_FRM = 4,
  parameter int ERR_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] local_score,
  input  logic               local_pause,
  input  logic               local_reload,
  output logic               tx_line,
  input  logic               rx_line,
  output logic [SCORE_W-1:0] peer_score,
  output logic               peer_pause,
  output logic               peer_reload,
  output logic               peer_reload_tick,
  output logic               peer_connected,
  output logic [ERR_W-1:0]   frame_err_ctr
);

  localparam int P          = SCORE_W + 2;
  localparam int FRAME_BITS = P + 3 + IDLE_BITS;
  localparam int TMO_LIMIT  = TIMEOUT_FRM * FRAME_BITS * BIT_CYCLES;
  localparam int TMO_W      = $clog2(TMO_LIMIT + 1);
  localparam int BC_W       = $clog2(BIT_CYCLES + 1);
  localparam int CNT_MAX    = (P > IDLE_BITS) ? P : IDLE_BITS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(BIT_CYCLES - 1);
  localparam logic [BC_W-1:0]  BIT_FULL = BC_W'(BIT_CYCLES);
  localparam logic [BC_W-1:0]  BIT_HALF = BC_W'(BIT_CYCLES / 2);
  localparam logic [BC_W-1:0]  BIT_ONE  = BC_W'(1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(P - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(IDLE_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TMO_LIMIT);
  localparam logic [TMO_W-1:0] TMO_PRE   = TMO_W'(TMO_LIMIT - 1);

  // TX states
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;
  localparam logic [2:0] TX_GAP    = 3'd5;

  // RX states
  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START_CHK = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_PARITY    = 3'd3;
  localparam logic [2:0] RX_STOP      = 3'd4;

  // ------------------------------------------------------------------ TX
  logic [2:0]       tx_state;
  logic [BC_W-1:0]  tx_timer;
  logic [CNT_W-1:0] tx_idx;
  logic [P-1:0]     tx_shift;
  logic             tx_par;
  logic             tx_bit;
  logic             tx_bit_end;

  assign tx_bit_end = (tx_timer == BIT_LAST);

  // Line level for the current state; registered into tx_line one cycle later,
  // which shifts every bit by the same amount and keeps bit widths exact.
  always_comb begin
    tx_bit = 1'b1;
    case (tx_state)
      TX_START:  tx_bit = 1'b0;
      TX_DATA:   tx_bit = tx_shift[0];
      TX_PARITY: tx_bit = tx_par;
      default:   tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      tx_line <= tx_bit;
      if (tx_state == TX_IDLE) begin
        tx_timer <= '0;
      end else begin
        tx_timer <= tx_bit_end ? '0 : tx_timer + 1'b1;
      end
      case (tx_state)
        TX_IDLE: begin
          tx_state <= TX_START;
        end
        TX_START: begin
          if (tx_timer == '0) begin
            tx_shift <= {local_reload, local_pause, local_score};
            tx_par   <= ^{local_reload, local_pause, local_score};
          end
          if (tx_bit_end) begin
            tx_state <= TX_DATA;
            tx_idx   <= '0;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_shift <= tx_shift >> 1;
            if (tx_idx == DATA_LAST) begin
              tx_state <= TX_PARITY;
            end
            tx_idx <= tx_idx + 1'b1;
          end
        end
        TX_PARITY: begin
          if (tx_bit_end) tx_state <= TX_STOP;
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_state <= TX_GAP;
            tx_idx   <= '0;
          end
        end
        TX_GAP: begin
          if (tx_bit_end) begin
            if (tx_idx == GAP_LAST) begin
              tx_state <= TX_START;
            end
            tx_idx <= tx_idx + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------ RX
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [2:0]       rx_state;
  logic [BC_W-1:0]  rx_timer;
  logic [CNT_W-1:0] rx_idx;
  logic [P-1:0]     rx_shift;
  logic             rx_par;
  logic             rx_sample;
  logic             stop_sample;
  logic             frame_ok;
  logic             frame_bad;

  // The timer counts cycles since the falling edge (or the previous sample),
  // so the start bit is probed mid-bit and later bits a full bit apart.
  always_comb begin
    rx_sample = 1'b0;
    case (rx_state)
      RX_START_CHK: rx_sample = (rx_timer == BIT_HALF);
      RX_DATA, RX_PARITY, RX_STOP: rx_sample = (rx_timer == BIT_FULL);
      default: rx_sample = 1'b0;
    endcase
  end

  assign stop_sample = rx_sample && (rx_state == RX_STOP);
  assign frame_ok    = stop_sample && rx_sync && (rx_par == ^rx_shift);
  assign frame_bad   = stop_sample && !frame_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchroniser reloads to the idle level so a released line is not seen as an edge.
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_timer <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_meta <= rx_line;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (rx_state != RX_IDLE) begin
        rx_timer <= rx_sample ? BIT_ONE : rx_timer + 1'b1;
      end
      case (rx_state)
        RX_IDLE: begin
          // Needs a genuine high->low edge, so a stop bit stuck low re-arms only
          // after the line has returned high.
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START_CHK;
            rx_timer <= BIT_ONE;
          end
        end
        RX_START_CHK: begin
          if (rx_sample) begin
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
            rx_idx   <= '0;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_shift <= {rx_sync, rx_shift[P-1:1]};
            if (rx_idx == DATA_LAST) begin
              rx_state <= RX_PARITY;
            end
            rx_idx <= rx_idx + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_sample) begin
            rx_par   <= rx_sync;
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_sample) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------ peer state / supervision
  logic [TMO_W-1:0] tmo_ctr;

  always_ff @(posedge clk) begin
    if (rst) begin
      peer_score       <= '0;
      peer_pause       <= 1'b0;
      peer_reload      <= 1'b0;
      peer_reload_tick <= 1'b0;
      peer_connected   <= 1'b0;
      frame_err_ctr    <= '0;
      tmo_ctr          <= '0;
    end else begin
      peer_reload_tick <= 1'b0;
      if (frame_ok) begin
        peer_score       <= rx_shift[SCORE_W-1:0];
        peer_pause       <= rx_shift[SCORE_W];
        peer_reload      <= rx_shift[SCORE_W+1];
        peer_reload_tick <= rx_shift[SCORE_W+1] & ~peer_reload;
        peer_connected   <= 1'b1;
        tmo_ctr          <= '0;
      end else begin
        if (tmo_ctr != TMO_MAX) begin
          tmo_ctr <= tmo_ctr + 1'b1;
        end
        // Clear on the edge that brings the counter to its limit so the outputs are
        // already low on the cycle the counter reads T. No tick on this path.
        if (tmo_ctr == TMO_PRE) begin
          peer_connected <= 1'b0;
          peer_score     <= '0;
          peer_pause     <= 1'b0;
          peer_reload    <= 1'b0;
        end
      end
      if (frame_bad && (frame_err_ctr != '1)) begin
        frame_err_ctr <= frame_err_ctr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mp_serial_link.sv
// Testbench for mp_serial_link: loopback and injected frames, scoreboard checked by a
// monitor that pops one expected state per observed change of the peer outputs.
module tb_mp_serial_link;

  localparam int SW    = 4;
  localparam int BC    = 20;
  localparam int IB    = 2;
  localparam int TF    = 4;
  localparam int EW    = 8;
  localparam int P     = SW + 2;
  localparam int FRAME = (P + 3 + IB) * BC;
  localparam int T     = TF * FRAME;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [SW-1:0] local_score;
  logic          local_pause;
  logic          local_reload;
  logic          tx_line;
  logic          rx_line;
  logic [SW-1:0] peer_score;
  logic          peer_pause;
  logic          peer_reload;
  logic          peer_reload_tick;
  logic          peer_connected;
  logic [EW-1:0] frame_err_ctr;

  logic loop_en = 1'b1;
  logic drv_rx  = 1'b1;
  assign rx_line = loop_en ? tx_line : drv_rx;

  mp_serial_link #(
    .SCORE_W(SW), .BIT_CYCLES(BC), .IDLE_BITS(IB), .TIMEOUT_FRM(TF), .ERR_W(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .local_score(local_score), .local_pause(local_pause), .local_reload(local_reload),
    .tx_line(tx_line), .rx_line(rx_line),
    .peer_score(peer_score), .peer_pause(peer_pause), .peer_reload(peer_reload),
    .peer_reload_tick(peer_reload_tick), .peer_connected(peer_connected),
    .frame_err_ctr(frame_err_ctr)
  );

  // ------------------------------------------------------------ scoreboard + model
  typedef struct {
    int            kind;   // 0 good frame, 1 rejected frame, 2 link timeout
    logic [SW-1:0] score;
    logic          pause;
    logic          reload;
    logic          tick;
    logic [EW-1:0] err;
    logic          conn;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_good_cyc = 0;
  int tick_count = 0;

  logic [SW-1:0] m_score  = '0;
  logic          m_pause  = 1'b0;
  logic          m_reload = 1'b0;
  logic [EW-1:0] m_err    = '0;
  logic          m_conn   = 1'b0;
  int            m_ticks  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, want, $time);
  endtask

  task automatic push_good(input logic [SW-1:0] s, input logic p, input logic r);
    exp_t e;
    e.kind = 0; e.score = s; e.pause = p; e.reload = r;
    e.tick = r & ~m_reload;
    if (e.tick) m_ticks++;
    m_score = s; m_pause = p; m_reload = r; m_conn = 1'b1;
    e.err = m_err; e.conn = 1'b1;
    sb.push_back(e);
    $display("push good   score=%0d pause=%0b reload=%0b tick=%0b", s, p, r, e.tick);
  endtask

  task automatic push_err();
    exp_t e;
    if (m_err != '1) m_err = m_err + 1'b1;
    e.kind = 1; e.score = m_score; e.pause = m_pause; e.reload = m_reload;
    e.tick = 1'b0; e.err = m_err; e.conn = m_conn;
    sb.push_back(e);
    $display("push reject err=%0d", m_err);
  endtask

  task automatic push_timeout();
    exp_t e;
    m_score = '0; m_pause = 1'b0; m_reload = 1'b0; m_conn = 1'b0;
    e.kind = 2; e.score = '0; e.pause = 1'b0; e.reload = 1'b0;
    e.tick = 1'b0; e.err = m_err; e.conn = 1'b0;
    sb.push_back(e);
    $display("push timeout");
  endtask

  // ------------------------------------------------------------ monitor
  logic [SW+EW+2:0] snap;
  logic [SW+EW+2:0] prev_snap = '0;

  always @(negedge clk) begin
    exp_t e;
    snap = {peer_score, peer_pause, peer_reload, frame_err_ctr, peer_connected};
    if (rst) begin
      prev_snap = snap;
    end else begin
      if (peer_reload_tick) tick_count++;
      if (snap != prev_snap) begin
        prev_snap = snap;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got 0x%0h required no output change (t=%0t)", snap, $time);
        end else begin
          e = sb.pop_front();
          check(e.kind == 0 ? "good_frame" : (e.kind == 1 ? "reject_frame" : "timeout_state"),
                64'({peer_score, peer_pause, peer_reload, peer_reload_tick, frame_err_ctr, peer_connected}),
                64'({e.score, e.pause, e.reload, e.tick, e.err, e.conn}));
          $display("event kind=%0d score=%0d pause=%0b reload=%0b tick=%0b err=%0d conn=%0b",
                   e.kind, peer_score, peer_pause, peer_reload, peer_reload_tick,
                   frame_err_ctr, peer_connected);
          if (e.kind == 2) check("timeout_delay", 64'(cyc - last_good_cyc), 64'(T));
          if (e.kind == 0) last_good_cyc = cyc;
        end
      end
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  task automatic wait_drain(input int maxc, input string name);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else begin
      $display("FAIL %s: %0d expected events still pending after %0d cycles, required 0", name, sb.size(), maxc);
      sb.delete();
    end
  endtask

  task automatic wait_tx_fall(input int maxc);
    int   n = 0;
    logic last = tx_line;
    logic seen = 1'b0;
    while (!seen && n < maxc) begin
      @(posedge clk); #1;
      if (last && !tx_line) seen = 1'b1;
      last = tx_line;
      n++;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL tx_start_edge: got no falling edge in %0d cycles, required one", maxc);
    end
  endtask

  task automatic drive_bit(input logic b);
    drv_rx = b;
    repeat (BC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [SW-1:0] s, input logic p, input logic r,
                            input logic flip_par, input logic bad_stop);
    logic [P-1:0] pl;
    pl = {r, p, s};
    drive_bit(1'b0);
    for (int i = 0; i < P; i++) drive_bit(pl[i]);
    drive_bit((^pl) ^ flip_par);
    if (bad_stop) begin
      drive_bit(1'b0);
      drive_bit(1'b0);
    end else begin
      drive_bit(1'b1);
    end
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic send_good_random();
    logic [SW-1:0] s;
    logic p, r;
    do begin
      s = SW'($urandom);
      p = 1'($urandom);
      r = 1'($urandom);
    end while ({s, p, r} == {m_score, m_pause, m_reload});
    push_good(s, p, r);
    send_frame(s, p, r, 1'b0, 1'b0);
    wait_drain(FRAME, "good_drain");
  endtask

  // ------------------------------------------------------------ main sequence
  initial begin
    logic prev_bad;
    int   k;
    local_score = 4'd9; local_pause = 1'b1; local_reload = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          64'({tx_line, peer_score, peer_pause, peer_reload, peer_reload_tick, peer_connected, frame_err_ctr}),
          64'({1'b1, {(SW + 4 + EW){1'b0}}}));
    @(posedge clk); #1;
    rst = 1'b0;

    // Loopback: first frame within the latency bound
    push_good(4'd9, 1'b1, 1'b0);
    wait_drain(2 * FRAME + 4, "loopback_latency");

    // Reload rises: exactly one tick
    local_reload = 1'b1;
    push_good(4'd9, 1'b1, 1'b1);
    wait_drain(2 * FRAME + 4, "reload_latency");
    repeat (2 * FRAME) @(posedge clk);
    #1;
    check("reload_tick_count", 64'(tick_count), 64'(m_ticks));

    // Reset mid-DATA on both TX and RX (loopback)
    wait_tx_fall(2 * FRAME);
    repeat (3 * BC) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midframe_reset_outputs",
          64'({tx_line, peer_score, peer_pause, peer_reload, peer_reload_tick, peer_connected, frame_err_ctr}),
          64'({1'b1, {(SW + 4 + EW){1'b0}}}));
    @(posedge clk); #1;
    rst = 1'b0;
    m_score = '0; m_pause = 1'b0; m_reload = 1'b0; m_err = '0; m_conn = 1'b0;
    push_good(4'd9, 1'b1, 1'b1);
    wait_drain(2 * FRAME + 4, "post_reset_frame");

    // Hand the RX line over to the bench during the TX inter-frame gap
    wait_tx_fall(2 * FRAME);
    repeat ((P + 3) * BC + 5) @(posedge clk);
    #1;
    drv_rx  = 1'b1;
    loop_en = 1'b0;

    // Parity-flipped frame with score 5, then a good frame
    push_err();
    send_frame(4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_drain(FRAME, "parity_err_drain");
    send_good_random();

    // Short low glitch on idle line: no frame, no error
    drv_rx = 1'b0;
    repeat (BC / 2 - 4) @(posedge clk);
    #1;
    drv_rx = 1'b1;
    repeat (FRAME) @(posedge clk);
    #1;
    check("glitch_no_error", 64'(frame_err_ctr), 64'(m_err));
    send_good_random();

    // Stop bit held low, then recovery
    push_err();
    send_frame(SW'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
    wait_drain(FRAME, "stop_err_drain");
    send_good_random();

    // Random mix; never two rejects in a row so the link stays up
    prev_bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 9);
      if (prev_bad || i == 11 || k > 1) begin
        send_good_random();
        prev_bad = 1'b0;
      end else begin
        push_err();
        send_frame(SW'($urandom), 1'($urandom), 1'($urandom), (k == 0), (k == 1));
        wait_drain(FRAME, "random_err_drain");
        prev_bad = 1'b1;
      end
    end

    // Line held high: link times out exactly T cycles after the last update
    push_timeout();
    wait_drain(T + FRAME, "timeout_drain");
    repeat (FRAME) @(posedge clk);
    #1;
    check("final_tick_count", 64'(tick_count), 64'(m_ticks));
    check("final_err_ctr", 64'(frame_err_ctr), 64'(m_err));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
